// File: rtl/rf_dump.sv
// rf_dump: walks the register file debug read port from address 0 to
// NREGS-1 and streams each 32-bit word as four bytes, MSB first, over a
// valid/ready byte interface. The architectural write path is never touched.
module rf_dump #(
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [31:0]       rf_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        cnt_q, cnt_d;
  // The top byte goes straight from rf_data to tx_data in FETCH, so only
  // the remaining three bytes of the word need to be held for shifting.
  logic [23:0]       shreg_q, shreg_d;

  logic hs;
  logic last_byte;
  logic last_reg;

  assign hs        = tx_valid_q && tx_ready;
  assign last_byte = (cnt_q == 2'd3);
  assign last_reg  = (rf_addr_q == LAST_ADDR);

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   state_d = SEND;
        SEND:    if (hs && last_byte) state_d = last_reg ? FIN : FETCH;
        FIN:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output/datapath next values: capture, byte shifting and address walk.
  always_comb begin
    rf_addr_d  = rf_addr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    unique case (state_q)
      IDLE: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
        if (start && !abort) begin
          rf_addr_d = '0;
          busy_d    = 1'b1;
        end
      end
      FETCH: begin
        // Whole word sampled in one cycle so it can never be torn.
        shreg_d    = rf_data[23:0];
        tx_data_d  = rf_data[31:24];
        tx_valid_d = 1'b1;
        cnt_d      = 2'd0;
      end
      SEND: begin
        if (hs) begin
          shreg_d   = {shreg_q[15:0], 8'h00};
          tx_data_d = shreg_q[23:16];
          cnt_d     = cnt_q + 2'd1;
          if (last_byte) begin
            tx_valid_d = 1'b0;
            if (last_reg) begin
              done_d = 1'b1;
            end else begin
              rf_addr_d = rf_addr_q + ADDR_W'(1);
            end
          end
        end
      end
      FIN: begin
        busy_d = 1'b0;
      end
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
    // A byte handshaking alongside abort is already delivered; only the
    // rest of the stream is dropped.
    if (abort) begin
      tx_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end
  end

  // Datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_addr_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      shreg_q    <= '0;
    end else begin
      rf_addr_q  <= rf_addr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  assign rf_addr  = rf_addr_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rf_dump.sv
// tb_rf_dump: directed bench for rf_dump with a behavioural register file,
// a negedge stream monitor and hand-computed expected streams.
module tb_rf_dump;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b0;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              tx_ready = 1'b1;
  logic [ADDR_W-1:0] rf_addr;
  logic [31:0]       rf_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              busy;
  logic              done;

  logic [31:0] regs     [NREGS];
  logic [31:0] exp_regs [NREGS];

  assign rf_data = regs[rf_addr];

  always #5 clk = ~clk;

  rf_dump #(.NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Monitor state (written only by the monitor process).
  logic [7:0] got_q [$];
  int         hs_cyc [$];
  int         cyc      = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  // Sample the stream mid-cycle: values seen here are what the next edge uses.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_stall && !(tx_valid && tx_data == prev_data)) stab_err = stab_err + 1;
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) begin
      got_q.push_back(tx_data);
      hs_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
      $display("ok   %s got 0x%0h", tag, got);
    end else begin
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
    end
    tx_ready = 1'b1;
  endtask

  task automatic wait_bytes(input int base, input int n, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (got_q.size() - base >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic check_stream(input string tag, input int base);
    int err;
    logic [31:0] w;
    logic [7:0]  eb;
    err = 0;
    check({tag, "_len"}, 32'(got_q.size() - base), 32'd128);
    for (int i = 0; i < 128; i++) begin
      if (base + i >= got_q.size()) begin
        err = err + 1;
      end else begin
        w  = exp_regs[i / 4];
        eb = 8'(w >> (24 - 8 * (i % 4)));
        if (got_q[base + i] !== eb) err = err + 1;
      end
    end
    check({tag, "_bytes_bad"}, 32'(err), 32'd0);
  endtask

  int base, bbase, dbase, sbase, err;
  bit ok;

  initial begin
    for (int i = 0; i < NREGS; i++) begin
      regs[i]     = 32'h0101_0101 * i;
      exp_regs[i] = 32'h0101_0101 * i;
    end

    // Reset state
    repeat (2) tick();
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_rf_addr",  32'(rf_addr),  32'd0);
    check("rst_tx_data",  32'(tx_data),  32'd0);
    rst_n = 1'b1;
    tick();

    // Full dump with tx_ready tied high
    base = got_q.size(); bbase = busy_cnt; dbase = done_cnt;
    pulse_start();
    check("t1_busy_on", 32'(busy), 32'd1);
    check("t1_addr0",   32'(rf_addr), 32'd0);
    wait_done(400, 1'b0, ok);
    check("t1_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t1", base);
    check("t1_busy_cycles", 32'(busy_cnt - bbase), 32'd161);
    check("t1_done_pulses", 32'(done_cnt - dbase), 32'd1);
    check("t1_done_after_last", 32'(done_cyc - hs_cyc[hs_cyc.size() - 1]), 32'd1);
    err = 0;
    if (got_q.size() - base < 128) err = 1;
    else
      for (int i = 0; i < 128; i++)
        if (hs_cyc[base + i] - hs_cyc[base] != 5 * (i / 4) + (i % 4)) err = err + 1;
    check("t1_cadence_bad", 32'(err), 32'd0);
    check("t1_idle_busy",  32'(busy),    32'd0);
    check("t1_addr_kept",  32'(rf_addr), 32'd31);

    // Random backpressure, R5 distinctive
    regs[5] = 32'hDEAD_BEEF; exp_regs[5] = 32'hDEAD_BEEF;
    base = got_q.size(); sbase = stab_err;
    pulse_start();
    wait_done(2000, 1'b1, ok);
    check("t2_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t2", base);
    check("t2_pos20", 32'(got_q[base + 20]), 32'hDE);
    check("t2_pos21", 32'(got_q[base + 21]), 32'hAD);
    check("t2_pos22", 32'(got_q[base + 22]), 32'hBE);
    check("t2_pos23", 32'(got_q[base + 23]), 32'hEF);
    check("t2_stall_stable_bad", 32'(stab_err - sbase), 32'd0);

    // Long stall on byte 2 of R3
    regs[3] = 32'h1122_3344; exp_regs[3] = 32'h1122_3344;
    base = got_q.size();
    pulse_start();
    wait_bytes(base, 14, 200, ok);
    check("t3_reach_b14", 32'(ok), 32'd1);
    tx_ready = 1'b0;
    err = 0;
    repeat (50) begin
      tick();
      if (!(tx_valid && tx_data == 8'h33 && rf_addr == 5'd3)) err = err + 1;
    end
    check("t3_hold_bad", 32'(err), 32'd0);
    check("t3_no_bytes_in_stall", 32'(got_q.size() - base), 32'd14);
    tx_ready = 1'b1;
    wait_done(400, 1'b0, ok);
    check("t3_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t3", base);

    // Abort during R10 byte 1
    base = got_q.size(); dbase = done_cnt;
    pulse_start();
    wait_bytes(base, 41, 400, ok);
    check("t4_reach_b41", 32'(ok), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_valid_off", 32'(tx_valid), 32'd0);
    check("t4_busy_off",  32'(busy),     32'd0);
    repeat (5) tick();
    check("t4_bytes_delivered", 32'(got_q.size() - base), 32'd42);
    check("t4_last_byte", 32'(got_q[base + 41]), 32'h0A);
    check("t4_no_done",   32'(done_cnt - dbase), 32'd0);
    base = got_q.size();
    pulse_start();
    check("t4_restart_addr", 32'(rf_addr), 32'd0);
    check("t4_restart_busy", 32'(busy), 32'd1);
    wait_done(400, 1'b0, ok);
    check("t4_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t4", base);

    // Asynchronous reset mid-SEND, then start re-pulsed while busy
    base = got_q.size();
    pulse_start();
    wait_bytes(base, 6, 200, ok);
    check("t5_reach_b6", 32'(ok), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(tx_valid), 32'd0);
    check("t5_rst_busy",  32'(busy),     32'd0);
    check("t5_rst_addr",  32'(rf_addr),  32'd0);
    tick();
    tick();
    check("t5_no_more_bytes", 32'(got_q.size() - base), 32'd6);
    rst_n = 1'b1;
    tick();
    base = got_q.size(); dbase = done_cnt;
    pulse_start();
    repeat (20) tick();
    pulse_start();
    wait_done(400, 1'b0, ok);
    check("t5_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t5", base);
    check("t5_done_pulses", 32'(done_cnt - dbase), 32'd1);

    // R31 written shortly before its FETCH: new value streamed
    base = got_q.size();
    pulse_start();
    wait_bytes(base, 122, 400, ok);
    check("t6a_reach", 32'(ok), 32'd1);
    regs[31] = 32'h1234_5678; exp_regs[31] = 32'h1234_5678;
    wait_done(400, 1'b0, ok);
    check("t6a_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t6a", base);
    check("t6a_b124", 32'(got_q[base + 124]), 32'h12);
    check("t6a_b127", 32'(got_q[base + 127]), 32'h78);

    // R31 written during its SEND: old value streamed unchanged
    regs[31] = 32'h1F1F_1F1F; exp_regs[31] = 32'h1F1F_1F1F;
    base = got_q.size();
    pulse_start();
    wait_bytes(base, 125, 400, ok);
    check("t6b_reach", 32'(ok), 32'd1);
    regs[31] = 32'h1234_5678;
    wait_done(400, 1'b0, ok);
    check("t6b_done_seen", 32'(ok), 32'd1);
    repeat (3) tick();
    check_stream("t6b", base);
    check("t6b_b125", 32'(got_q[base + 125]), 32'h1F);
    check("t6b_b127", 32'(got_q[base + 127]), 32'h1F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_dump.md
Name: rf_dump

Overview:
- Read-side master for the register file's debug read port (rf_addr/rf_data).
- On a start request it walks every register address in order and captures each 32-bit word.
- Each word is sent as 4 bytes, MSB first, on a valid/ready byte stream toward the board debug/display link.
- Sits beside the datapath register file; it never touches the architectural write path.

Parameters:
- NREGS, 32, number of registers scanned (addresses 0..NREGS-1).
- ADDR_W, 5, width of rf_addr; must satisfy 2**ADDR_W >= NREGS.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a full dump; sampled in IDLE only.
- abort  in  1  synchronous abort of a dump in progress.
- rf_addr  out  ADDR_W  debug read address to the register file; registered.
- rf_data  in  32  debug read data from the register file; combinational in rf_addr.
- tx_data  out  8  stream byte.
- tx_valid  out  1  stream byte valid.
- tx_ready  in  1  sink accepts the byte when tx_valid&&tx_ready at a rising edge.
- busy  out  1  high from the cycle after start is accepted until the dump ends.
- done  out  1  one-cycle pulse after the last byte of register NREGS-1 is accepted.

Behaviour:
- Reset values (Rst_n low, asynchronous): state IDLE, rf_addr=0, tx_data=0, tx_valid=0, busy=0, done=0, byte counter=0, shift register=0.
- States: IDLE, FETCH, SEND, FIN.
- IDLE:
  - tx_valid=0, busy=0.
  - start=1 -> rf_addr<=0, busy<=1, next state FETCH.
- FETCH (exactly 1 cycle):
  - Capture shreg<=rf_data for the current rf_addr.
  - Drive tx_data<=rf_data[31:24], tx_valid<=1, byte counter<=0, next state SEND.
- SEND:
  - tx_valid and tx_data hold stable until the handshake.
  - On handshake: shreg shifts left 8 and tx_data takes the next byte; counter increments.
  - Handshake on byte 3 with rf_addr!=NREGS-1 -> tx_valid<=0, rf_addr<=rf_addr+1, next state FETCH.
  - Handshake on byte 3 with rf_addr==NREGS-1 -> tx_valid<=0, next state FIN.
- FIN (1 cycle): done=1, busy<=0, next state IDLE. rf_addr keeps NREGS-1 until the next start.
- Throughput: 5 cycles per register with tx_ready tied high; full default dump is 160 cycles from the start edge to the last handshake, with done in the following cycle.
- tx_ready low: stall indefinitely in SEND; no byte is dropped or duplicated.
- abort=1 in FETCH, SEND or FIN (priority over everything except reset):
  - Next cycle: IDLE, tx_valid=0, busy=0, no done pulse.
  - A byte handshaking in the same cycle as abort counts as delivered; the stream is simply truncated.
- start while busy: ignored. start and abort together in IDLE: abort wins, stay IDLE.
- Coherency: each word reflects rf_data in its own FETCH cycle. Writes to the register file during a dump are not excluded; a word is never torn because it is captured in one cycle.
- Register 0 is dumped as stored, with no zero-forcing.
- Asynchronous reset mid-dump: outputs drop to reset values immediately; no further bytes.

Test Plan:
- Regs R[i]=0x01010101*i, tx_ready=1, pulse start -> 128 bytes 00 00 00 00, 01 01 01 01 … 1F 1F 1F 1F on consecutive handshakes (FETCH gaps every 5th cycle); done one cycle after the last byte; busy high 161 cycles.
- R[5]=0xDEADBEEF, tx_ready toggled 1/0 randomly -> bytes DE AD BE EF at stream positions 20..23; tx_data stable whenever tx_valid&&!tx_ready.
- Hold tx_ready=0 for 50 cycles during byte 2 of R[3] -> tx_valid stays 1 and tx_data stays constant; rf_addr stays 3; stream resumes with no loss.
- abort asserted during R[10] byte 1 -> tx_valid=0 and busy=0 next cycle, no done pulse; a fresh start restarts at rf_addr=0.
- Rst_n pulled low mid-SEND without a clock edge -> tx_valid, busy and rf_addr read 0 immediately; start re-pulsed during busy is ignored (byte count stays 128).
- Write R[31]=0x12345678 two cycles before its FETCH versus during its SEND -> first case streams 12 34 56 78; second case streams the old value unchanged.
